// File: rtl/fft_stream_adapter.sv
// Streaming valid/ready front/back end for the parallel radix-4 FFT core:
// collects one frame, starts the core, captures its result and replays it bin by bin.
module fft_stream_adapter #(
  parameter int WIDTH    = 16,
  parameter int N_POINTS = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_real,
  input  logic [WIDTH-1:0]          s_imag,
  input  logic                      s_last,
  input  logic                      reorder_en,
  output logic                      core_start,
  output logic [WIDTH*N_POINTS-1:0] core_din_real,
  output logic [WIDTH*N_POINTS-1:0] core_din_imag,
  input  logic [WIDTH*N_POINTS-1:0] core_dout_real,
  input  logic [WIDTH*N_POINTS-1:0] core_dout_imag,
  input  logic                      core_done,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_real,
  output logic [WIDTH-1:0]          m_imag,
  output logic [$clog2(N_POINTS)-1:0] m_index,
  output logic                      m_last,
  output logic                      err_short,
  output logic                      err_long,
  output logic                      err_timeout,
  output logic                      busy
);

  localparam int IW = $clog2(N_POINTS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = WIDTH * N_POINTS;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_POINTS - 1);
  localparam logic [TW-1:0] LAST_T   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} state_t;

  state_t          state;
  logic [IW-1:0]   wr_cnt;
  logic [IW-1:0]   rd_cnt;
  logic [TW-1:0]   t_cnt;
  logic            reorder;
  logic [FW-1:0]   din_real;
  logic [FW-1:0]   din_imag;
  logic [FW-1:0]   out_real;
  logic [FW-1:0]   out_imag;
  logic [IW-1:0]   nxt_idx;
  logic [IW-1:0]   nxt_sel;

  // Reverse the base-4 digits of an index (IW is even for a power-of-4 N).
  function automatic logic [IW-1:0] digitrev4(input logic [IW-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int unsigned d = 0; d < IW / 2; d++) begin
      r[2*d +: 2] = v[IW-2-2*d +: 2];
    end
    return r;
  endfunction

  assign core_din_real = din_real;
  assign core_din_imag = din_imag;

  always_comb begin
    nxt_idx = rd_cnt + 1'b1;
    nxt_sel = reorder ? digitrev4(nxt_idx) : nxt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      t_cnt       <= '0;
      reorder     <= 1'b0;
      din_real    <= '0;
      din_imag    <= '0;
      out_real    <= '0;
      out_imag    <= '0;
      s_ready     <= 1'b1;
      core_start  <= 1'b0;
      m_valid     <= 1'b0;
      m_real      <= '0;
      m_imag      <= '0;
      m_index     <= '0;
      m_last      <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        FILL: begin
          if (s_valid && s_ready) begin
            if (wr_cnt == '0) reorder <= reorder_en;
            // An early s_last zero-pads every slot above the one being written.
            for (int unsigned j = 0; j < N_POINTS; j++) begin
              if (j == int'(wr_cnt)) begin
                din_real[j*WIDTH +: WIDTH] <= s_real;
                din_imag[j*WIDTH +: WIDTH] <= s_imag;
              end else if (s_last && j > int'(wr_cnt)) begin
                din_real[j*WIDTH +: WIDTH] <= '0;
                din_imag[j*WIDTH +: WIDTH] <= '0;
              end
            end
            if (wr_cnt == LAST_IDX || s_last) begin
              state      <= START;
              s_ready    <= 1'b0;
              busy       <= 1'b1;
              core_start <= 1'b1;
              t_cnt      <= '0;
              wr_cnt     <= '0;
              if (wr_cnt == LAST_IDX && !s_last) err_long  <= 1'b1;
              if (wr_cnt != LAST_IDX && s_last)  err_short <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        START: begin
          state <= WAIT;
          t_cnt <= t_cnt + 1'b1;
        end
        WAIT: begin
          if (core_done) begin
            out_real <= core_dout_real;
            out_imag <= core_dout_imag;
            state    <= DRAIN;
            rd_cnt   <= '0;
            // Bin 0 maps to slot 0 in both orders, so it comes straight off the core bus.
            m_valid  <= 1'b1;
            m_real   <= core_dout_real[WIDTH-1:0];
            m_imag   <= core_dout_imag[WIDTH-1:0];
            m_index  <= '0;
            m_last   <= 1'b0;
          end else if (t_cnt == LAST_T) begin
            err_timeout <= 1'b1;
            state       <= FILL;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (rd_cnt == LAST_IDX) begin
              state   <= FILL;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              s_ready <= 1'b1;
              busy    <= 1'b0;
            end else begin
              rd_cnt  <= nxt_idx;
              m_index <= nxt_idx;
              m_last  <= (nxt_idx == LAST_IDX);
              m_real  <= out_real[int'(nxt_sel)*WIDTH +: WIDTH];
              m_imag  <= out_imag[int'(nxt_sel)*WIDTH +: WIDTH];
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stream_adapter.sv
// Self-checking bench for fft_stream_adapter: a queue-based model of the expected
// output stream, a behavioural core stand-in, and one compare process on every negedge.
module tb_fft_stream_adapter;
  localparam int W  = 16;
  localparam int N  = 16;
  localparam int TO = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, s_valid, s_ready, s_last, reorder_en, core_start, core_done;
  logic m_valid, m_ready, m_last, err_short, err_long, err_timeout, busy;
  logic [W-1:0] s_real, s_imag, m_real, m_imag;
  logic [IW-1:0] m_index;
  logic [W*N-1:0] core_din_real, core_din_imag, core_dout_real, core_dout_imag;

  fft_stream_adapter #(.WIDTH(W), .N_POINTS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real),
    .s_imag(s_imag), .s_last(s_last), .reorder_en(reorder_en), .core_start(core_start),
    .core_din_real(core_din_real), .core_din_imag(core_din_imag),
    .core_dout_real(core_dout_real), .core_dout_imag(core_dout_imag),
    .core_done(core_done), .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real),
    .m_imag(m_imag), .m_index(m_index), .m_last(m_last), .err_short(err_short),
    .err_long(err_long), .err_timeout(err_timeout), .busy(busy)
  );

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  int n_checks = 0;
  int n_fail = 0;
  beat_t expq[$];
  logic [W-1:0] in_r[N], in_i[N], obs_r[N], obs_i[N];
  logic [W*N-1:0] exp_din_r, exp_din_i;
  bit exp_short, exp_long, exp_to;
  bit bp_en = 1'b0;

  task automatic check(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int drev(input int k);
    int r = 0;
    int v = k;
    for (int d = 0; d < IW / 2; d++) begin
      r = r * 4 + v % 4;
      v = v / 4;
    end
    return r;
  endfunction

  // Every valid beat must equal the head of the expected stream until it is taken.
  always @(negedge clk) begin
    if (rst === 1'b0 && m_valid === 1'b1) begin
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: m_valid=1 index=%0d, no beat expected", m_index);
      end else begin
        check($sformatf("beat[%0d]", expq[0].idx), {m_real, m_imag, m_index, m_last},
              {expq[0].re, expq[0].im, expq[0].idx, expq[0].last});
        if (m_ready) begin
          obs_r[m_index] = m_real;
          obs_i[m_index] = m_imag;
          void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_ready = bp_en ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic send_frame(input int len, input bit with_last, input bit rflag, input bit gaps);
    int idx = 0;
    int guard = 0;
    while (idx < len && guard < 500) begin
      @(posedge clk);
      #1;
      s_valid = gaps ? ($urandom % 4 != 0) : 1'b1;
      s_real = in_r[idx];
      s_imag = in_i[idx];
      s_last = with_last && (idx == len - 1);
      reorder_en = (idx == 0) ? rflag : 1'($urandom % 2);
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      guard++;
    end
    if (idx < len) check("fill_stall", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_real = W'($urandom);
    reorder_en = 1'($urandom % 2);
    if (with_last && len < N) exp_short = 1'b1;
    if (len == N && !with_last) exp_long = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_din_r[i*W +: W] = (i < len) ? in_r[i] : '0;
      exp_din_i[i*W +: W] = (i < len) ? in_i[i] : '0;
    end
    @(negedge clk);
    check("core_start_timing", core_start, 1);
    check("start_handshake", {s_ready, busy}, 2'b01);
    check("core_din_real", core_din_real, exp_din_r);
    check("core_din_imag", core_din_imag, exp_din_i);
    check("err_flags_at_start", {err_short, err_long, err_timeout}, {exp_short, exp_long, exp_to});
    @(negedge clk);
    check("core_start_pulse", core_start, 0);
  endtask

  task automatic finish_frame(input bit rflag, input bit rand_dout, input int lat, input int cut);
    logic [W-1:0] res_r[N], res_i[N];
    int guard = 0;
    repeat (lat - 1) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      res_r[i] = rand_dout ? W'($urandom) : exp_din_r[i*W +: W];
      res_i[i] = rand_dout ? W'($urandom) : exp_din_i[i*W +: W];
      core_dout_real[i*W +: W] = res_r[i];
      core_dout_imag[i*W +: W] = res_i[i];
    end
    core_done = 1'b1;
    for (int k = 0; k < N; k++) begin
      int src = rflag ? drev(k) : k;
      expq.push_back('{re: res_r[src], im: res_i[src], idx: IW'(k), last: (k == N - 1)});
    end
    @(posedge clk);
    #1;
    core_done = 1'b0;
    core_dout_real = {W*N/32{$urandom}};
    core_dout_imag = {W*N/32{$urandom}};
    @(negedge clk);
    check("m_valid_latency", m_valid, 1);
    while (expq.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (cut > 0 && N - expq.size() >= cut) break;
    end
    if (cut > 0) begin
      #2 rst = 1'b1;
      #1;
      check("rst_mid_drain", {m_valid, m_last, s_ready, busy, core_start}, 5'b00100);
      check("rst_clears_din", core_din_real, 0);
      expq.delete();
      exp_short = 1'b0;
      exp_long = 1'b0;
      exp_to = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end else begin
      if (expq.size() > 0) check("drain_timeout", expq.size(), 0);
      repeat (2) @(negedge clk);
      check("fill_after_drain", {m_valid, s_ready, busy}, 3'b010);
    end
  endtask

  initial begin
    int cycles;
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_real = '0;
    s_imag = '0;
    reorder_en = 1'b0;
    core_done = 1'b0;
    core_dout_real = '0;
    core_dout_imag = '0;
    exp_short = 1'b0;
    exp_long = 1'b0;
    exp_to = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_s_ready", s_ready, 1);
    check("reset_ctrl", {core_start, m_valid, m_last, busy, err_short, err_long, err_timeout}, 0);
    check("reset_din", {core_din_real, core_din_imag}, 0);
    check("reset_m_data", {m_real, m_imag, m_index}, 0);
    rst = 1'b0;

    // Natural order ramp, core echoes its input.
    for (int i = 0; i < N; i++) begin
      in_r[i] = W'(i);
      in_i[i] = W'(-i);
    end
    send_frame(N, 1, 0, 0);
    finish_frame(0, 0, 5, 0);
    check("pin_nat_r15", obs_r[15], 16'd15);
    check("pin_nat_i3", obs_i[3], 16'hFFFD);

    // Digit-reversed order of the same ramp.
    send_frame(N, 1, 1, 0);
    finish_frame(1, 0, 5, 0);
    check("pin_rev_r1", obs_r[1], 16'd4);
    check("pin_rev_r6", obs_r[6], 16'd9);
    check("pin_rev_i1", obs_i[1], 16'hFFFC);
    check("pin_rev_r15", obs_r[15], 16'd15);

    // Early s_last on the 10th sample.
    for (int i = 0; i < N; i++) in_r[i] = W'(i + 100);
    send_frame(10, 1, 0, 0);
    check("pin_short_slot9", core_din_real[9*W +: W], 16'd109);
    check("pin_short_slot10", core_din_real[10*W +: W], 16'd0);
    check("pin_err_short", err_short, 1);
    finish_frame(0, 0, 5, 0);

    // Full frame without s_last.
    send_frame(N, 0, 0, 0);
    check("pin_err_long", err_long, 1);
    finish_frame(0, 0, 3, 0);

    // core_done while idle must be ignored.
    @(posedge clk);
    #1 core_done = 1'b1;
    core_dout_real = {W*N/32{$urandom}};
    @(posedge clk);
    #1 core_done = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_done_ignored", {busy, s_ready, m_valid}, 3'b010);

    // Core never answers.
    send_frame(N, 1, 0, 1);
    cycles = 1;
    while (!err_timeout && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    exp_to = 1'b1;
    check("timeout_cycles", cycles, 64);
    check("timeout_to_fill", {s_ready, busy, m_valid}, 3'b100);

    // Random frames with backpressure and random core results.
    bp_en = 1'b1;
    repeat (6) begin
      int len = ($urandom % 3 == 0) ? 1 + int'($urandom % N) : N;
      bit wl = (len < N) ? 1'b1 : 1'($urandom % 2);
      bit rf = 1'($urandom % 2);
      for (int i = 0; i < N; i++) begin
        in_r[i] = W'($urandom);
        in_i[i] = W'($urandom);
      end
      send_frame(len, wl, rf, 1);
      finish_frame(rf, 1, 2 + int'($urandom % 6), 0);
    end

    // Asynchronous reset in the middle of DRAIN, then a clean frame.
    send_frame(N, 1, 1, 1);
    finish_frame(1, 1, 4, 5);
    check("errs_after_rst", {err_short, err_long, err_timeout}, 0);
    bp_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_r[i] = W'($urandom);
      in_i[i] = W'($urandom);
    end
    send_frame(N, 1, 0, 0);
    finish_frame(0, 1, 5, 0);
    check("errs_final", {err_short, err_long, err_timeout}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
